// File: rtl/load_response_unit.sv
// load_response_unit: single-outstanding load FSM bridging the MMU and D$ into a writeback result.
// Ports: clk_i/rst_i clock and async reset; clr_i sync clear; flush_i pipeline flush;
//        valid_i/vaddr_i/size_i/signed_i/trans_id_i load request, pop_ld_o consumes it;
//        translation_req_o/vaddr_o/dtlb_hit_i/paddr_i/ex_valid_i MMU handshake;
//        page_offset_o/page_offset_matches_i store-offset hazard check;
//        req_o/index_o/gnt_i/tag_valid_o/tag_o/kill_req_o/rvalid_i/rdata_i D$ port;
//        valid_o/trans_id_o/result_o/ex_o writeback.
module load_response_unit #(
  parameter int XLEN          = 64,
  parameter int VLEN          = 39,
  parameter int PLEN          = 56,
  parameter int TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clr_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  input  logic [VLEN-1:0]          vaddr_i,
  input  logic [1:0]               size_i,
  input  logic                     signed_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     pop_ld_o,
  output logic                     translation_req_o,
  output logic [VLEN-1:0]          vaddr_o,
  input  logic                     dtlb_hit_i,
  input  logic [PLEN-1:0]          paddr_i,
  input  logic                     ex_valid_i,
  output logic [11:0]              page_offset_o,
  input  logic                     page_offset_matches_i,
  output logic                     req_o,
  output logic [11:0]              index_o,
  input  logic                     gnt_i,
  output logic                     tag_valid_o,
  output logic [PLEN-13:0]         tag_o,
  output logic                     kill_req_o,
  input  logic                     rvalid_i,
  input  logic [XLEN-1:0]          rdata_i,
  output logic                     valid_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic [XLEN-1:0]          result_o,
  output logic                     ex_o
);
  typedef enum logic [2:0] {
    IDLE, WAIT_PAGE_OFFSET, WAIT_GNT, SEND_TAG, WAIT_TRANSLATION, WAIT_RVALID, WAIT_FLUSH
  } state_t;
  state_t state, state_n;
  logic [2:0] off_q;
  logic [1:0] size_q;
  logic signed_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic capture;
  logic active;
  logic [XLEN-1:0] shifted, loaded;
  logic unused_paddr;
  assign unused_paddr = ^paddr_i[11:0];
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      off_q    <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      id_q     <= '0;
    end else if (clr_i) begin
      state    <= IDLE;
      off_q    <= '0;
      size_q   <= '0;
      signed_q <= 1'b0;
      id_q     <= '0;
    end else begin
      state <= state_n;
      if (capture) begin
        off_q    <= vaddr_i[2:0];
        size_q   <= size_i;
        signed_q <= signed_i;
        id_q     <= trans_id_i;
      end
    end
  end
  // Address pass-throughs are only driven while a load is in flight or being offered,
  // so an idle unit presents all-zero outputs.
  assign active        = !rst_i && (state != IDLE || valid_i);
  assign vaddr_o       = active ? vaddr_i : '0;
  assign page_offset_o = active ? vaddr_i[11:0] : '0;
  assign index_o       = active ? vaddr_i[11:0] : '0;
  assign tag_o         = active ? paddr_i[PLEN-1:12] : '0;
  // D$ returns the whole aligned word; pick the addressed bytes and extend.
  assign shifted = rdata_i >> {off_q, 3'b000};
  assign loaded  = size_q == 2'd0 ? {{(XLEN-8){signed_q & shifted[7]}}, shifted[7:0]} :
                   size_q == 2'd1 ? {{(XLEN-16){signed_q & shifted[15]}}, shifted[15:0]} :
                   size_q == 2'd2 ? {{(XLEN-32){signed_q & shifted[31]}}, shifted[31:0]} :
                   shifted;
  always_comb begin
    state_n           = state;
    pop_ld_o          = 1'b0;
    translation_req_o = 1'b0;
    req_o             = 1'b0;
    tag_valid_o       = 1'b0;
    kill_req_o        = 1'b0;
    valid_o           = 1'b0;
    ex_o              = 1'b0;
    trans_id_o        = '0;
    result_o          = '0;
    capture           = 1'b0;
    if (!rst_i) begin
      case (state)
        IDLE, WAIT_PAGE_OFFSET: begin
          if (flush_i || !valid_i) state_n = IDLE;
          else if (page_offset_matches_i) state_n = WAIT_PAGE_OFFSET;
          else begin
            req_o   = 1'b1;
            state_n = gnt_i ? SEND_TAG : WAIT_GNT;
          end
        end
        WAIT_GNT: begin
          if (flush_i) state_n = IDLE;
          else begin
            req_o   = 1'b1;
            state_n = gnt_i ? SEND_TAG : WAIT_GNT;
          end
        end
        SEND_TAG: begin
          translation_req_o = 1'b1;
          if (flush_i) begin
            kill_req_o = 1'b1;
            state_n    = IDLE;
          end else if (ex_valid_i) begin
            kill_req_o = 1'b1;
            pop_ld_o   = 1'b1;
            valid_o    = 1'b1;
            ex_o       = 1'b1;
            trans_id_o = trans_id_i;
            state_n    = IDLE;
          end else if (dtlb_hit_i) begin
            tag_valid_o = 1'b1;
            pop_ld_o    = 1'b1;
            capture     = 1'b1;
            state_n     = WAIT_RVALID;
          end else begin
            // Miss: abandon this D$ access and re-issue from IDLE once the MMU has it.
            kill_req_o = 1'b1;
            state_n    = WAIT_TRANSLATION;
          end
        end
        WAIT_TRANSLATION: begin
          translation_req_o = 1'b1;
          if (flush_i || dtlb_hit_i) state_n = IDLE;
        end
        WAIT_RVALID: begin
          if (flush_i) state_n = rvalid_i ? IDLE : WAIT_FLUSH;
          else if (rvalid_i) begin
            valid_o    = 1'b1;
            trans_id_o = id_q;
            result_o   = loaded;
            state_n    = IDLE;
          end
        end
        WAIT_FLUSH: if (rvalid_i) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end
endmodule
